// File: rtl/spw_fifo_pkg.sv
// Shared types and constants for the SpaceWire receive packet FIFO.
// Contents:
//   spw_char_t    - 9-bit N-char; bit 8 is the control flag
//   SPW_EOP/EEP   - end-of-packet and error-end-of-packet markers
//   ovf_state_t   - overflow-recovery FSM states
//   is_end_marker - true for any control char (EOP/EEP)
package spw_fifo_pkg;

    typedef logic [8:0] spw_char_t;

    localparam spw_char_t SPW_EOP = 9'h100;
    localparam spw_char_t SPW_EEP = 9'h101;

    typedef enum logic [1:0] {
        NORMAL,
        PEND_EEP,
        DISCARD
    } ovf_state_t;

    function automatic logic is_end_marker(input spw_char_t c);
        return c[8];
    endfunction

endpackage

// File: rtl/spw_fifo_ram.sv
// Simple dual-port DEPTH x 9 storage with a registered read port.
// The array and the read register carry no reset.
// Ports:
//   clk            - clock
//   wrEn/wrAddr/wrData - write port
//   rdEn/rdAddr    - read request; rdData updates on the next edge, holds otherwise
module spw_fifo_ram
    import spw_fifo_pkg::*;
#(
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wrEn,
    input  logic [ADDR_WIDTH-1:0] wrAddr,
    input  spw_char_t             wrData,
    input  logic                  rdEn,
    input  logic [ADDR_WIDTH-1:0] rdAddr,
    output spw_char_t             rdData
);

    spw_char_t mem [DEPTH];

    // Read-before-write: when full, a same-cycle read and write hit the same
    // slot and the read must see the old head entry.
    always_ff @(posedge clk) begin
        if (wrEn) mem[wrAddr] <= wrData;
        if (rdEn) rdData <= mem[rdAddr];
    end

endmodule

// File: rtl/spw_rx_packet_fifo.sv
// Packet-aware receive FIFO between the SpaceWire codec and the RMAP target.
// On overflow the truncated packet is closed with an inserted EEP and the
// rest of it is discarded up to the next end marker.
// Ports:
//   clk, rst                  - clock, async active-high reset
//   spwDataIn/spwWriteEnable  - codec write side; spwFull when fillLevel == DEPTH
//   rxReadEnable/rxDataOut    - read side, 1-cycle read latency; rxEmpty when fillLevel == 0
//   flush                     - synchronous clear of stored contents
//   fillLevel, packetCount    - stored entries / stored end markers
//   overflowCount             - dropped external writes, saturating
module spw_rx_packet_fifo
    import spw_fifo_pkg::*;
#(
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [8:0]            spwDataIn,
    input  logic                  spwWriteEnable,
    output logic                  spwFull,
    input  logic                  rxReadEnable,
    output logic [8:0]            rxDataOut,
    output logic                  rxEmpty,
    input  logic                  flush,
    output logic [ADDR_WIDTH:0]   fillLevel,
    output logic [ADDR_WIDTH:0]   packetCount,
    output logic [CNT_WIDTH-1:0]  overflowCount
);

    localparam logic [ADDR_WIDTH:0] FULL_LVL = (ADDR_WIDTH+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wrPtr, rdPtr;
    ovf_state_t            state, nextState;
    logic                  discardFlag, nextDiscard;
    logic                  inPacket;
    logic                  readSeen;
    logic                  readAcc, room, extWr;
    logic                  doWrite, doDrop;
    logic                  wrEnd, rdEnd;
    spw_char_t             wrData, ramQ;
    logic [DEPTH-1:0]      endMark;

    assign spwFull = (fillLevel == FULL_LVL);
    assign rxEmpty = (fillLevel == '0);
    // RAM output has no reset; mask it until the first read since reset.
    assign rxDataOut = readSeen ? ramQ : 9'h000;

    always_comb begin
        readAcc     = rxReadEnable && !rxEmpty && !flush;
        room        = (fillLevel != FULL_LVL) || readAcc;
        extWr       = spwWriteEnable && !flush;
        doWrite     = 1'b0;
        doDrop      = 1'b0;
        wrData      = spwDataIn;
        nextState   = state;
        nextDiscard = discardFlag;
        if (flush) begin
            nextState   = (inPacket || (state != NORMAL && discardFlag)) ? DISCARD : NORMAL;
            nextDiscard = 1'b0;
        end else begin
            case (state)
                NORMAL: begin
                    if (extWr) begin
                        if (room) begin
                            doWrite = 1'b1;
                        end else begin
                            doDrop      = 1'b1;
                            nextState   = PEND_EEP;
                            nextDiscard = !is_end_marker(spwDataIn);
                        end
                    end
                end
                PEND_EEP: begin
                    doDrop = extWr;
                    if (extWr) nextDiscard = !is_end_marker(spwDataIn);
                    // The next state uses this cycle's updated flag, so an end
                    // marker dropped alongside the EEP insert skips DISCARD.
                    if (room) begin
                        doWrite   = 1'b1;
                        wrData    = SPW_EEP;
                        nextState = nextDiscard ? DISCARD : NORMAL;
                    end
                end
                DISCARD: begin
                    doDrop = extWr;
                    if (extWr && is_end_marker(spwDataIn)) begin
                        nextState   = NORMAL;
                        nextDiscard = 1'b0;
                    end
                end
                default: nextState = NORMAL;
            endcase
        end
        wrEnd = doWrite && is_end_marker(wrData);
        rdEnd = readAcc && endMark[rdPtr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr         <= '0;
            rdPtr         <= '0;
            fillLevel     <= '0;
            packetCount   <= '0;
            overflowCount <= '0;
            state         <= NORMAL;
            discardFlag   <= 1'b0;
            inPacket      <= 1'b0;
            readSeen      <= 1'b0;
        end else begin
            state       <= nextState;
            discardFlag <= nextDiscard;
            if (flush) begin
                wrPtr       <= '0;
                rdPtr       <= '0;
                fillLevel   <= '0;
                packetCount <= '0;
                inPacket    <= 1'b0;
            end else begin
                if (doWrite) wrPtr <= wrPtr + 1'b1;
                if (readAcc) rdPtr <= rdPtr + 1'b1;
                case ({doWrite, readAcc})
                    2'b10:   fillLevel <= fillLevel + 1'b1;
                    2'b01:   fillLevel <= fillLevel - 1'b1;
                    default: ;
                endcase
                case ({wrEnd, rdEnd})
                    2'b10:   packetCount <= packetCount + 1'b1;
                    2'b01:   packetCount <= packetCount - 1'b1;
                    default: ;
                endcase
                if (doWrite) inPacket <= !is_end_marker(wrData);
            end
            if (doDrop && overflowCount != '1) overflowCount <= overflowCount + 1'b1;
            if (readAcc) readSeen <= 1'b1;
        end
    end

    // Per-slot end-marker tag, so packetCount can drop on the read request
    // itself rather than one cycle later when the data leaves the RAM.
    always_ff @(posedge clk) begin
        if (doWrite) endMark[wrPtr] <= is_end_marker(wrData);
    end

    spw_fifo_ram #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) uRam (
        .clk    (clk),
        .wrEn   (doWrite),
        .wrAddr (wrPtr),
        .wrData (wrData),
        .rdEn   (readAcc),
        .rdAddr (rdPtr),
        .rdData (ramQ)
    );

endmodule
